// File: rtl/multi_input_or_accum.sv
// Frame accumulator: each accepted beat is OR/AND-reduced across its input words and folded into a running result.
// Optional per-frame beat counter output is enabled by defining MULTI_INPUT_OR_ACCUM_BEATCNT_EN.
module multi_input_or_accum #(
    parameter int NUM_INPUTS = 3,
    parameter int WIDTH      = 1,
    parameter int MODE       = 0,
    parameter int CNT_W      = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
    input  logic                        in_valid,
    input  logic                        in_last,
    output logic                        in_ready,
    output logic [WIDTH-1:0]            out_data,
    output logic                        out_any,
    output logic                        out_valid,
`ifdef MULTI_INPUT_OR_ACCUM_BEATCNT_EN
    output logic [CNT_W-1:0]            out_beats,
`endif
    input  logic                        out_ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Identity element of the reduction: all-zeros for OR, all-ones for AND.
    localparam logic [WIDTH-1:0] IDENT = (MODE == 1) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    if ((NUM_INPUTS < 2) || (NUM_INPUTS > 32) || (WIDTH < 1) || (WIDTH > 32) ||
        (MODE < 0) || (MODE > 1) || (CNT_W < 1)) begin : g_param_check
        $error("multi_input_or_accum: illegal parameter combination");
    end

    function automatic logic [WIDTH-1:0] combine(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] r;
        if (MODE == 1) begin
            r = a & b;
        end else begin
            r = a | b;
        end
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] reduce_beat(input logic [NUM_INPUTS*WIDTH-1:0] d);
        logic [WIDTH-1:0] r;
        r = d[0 +: WIDTH];
        for (int k = 1; k < NUM_INPUTS; k++) begin
            r = combine(r, d[k*WIDTH +: WIDTH]);
        end
        return r;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_nxt_s;
    logic [WIDTH-1:0] out_data_r;
    logic [WIDTH-1:0] out_data_nxt_s;
    logic             out_any_r;
    logic             out_any_nxt_s;
    logic             out_valid_r;
    logic             out_valid_nxt_s;
    logic             in_ready_s;
    logic             accept_s;
    logic             xfer_s;
    logic [WIDTH-1:0] beat_red_s;
    logic [WIDTH-1:0] frame_res_s;

    // Handshake qualifiers and the combinational beat reduction.
    always_comb begin
        in_ready_s  = (!out_valid_r) || out_ready;
        accept_s    = in_valid && in_ready_s;
        xfer_s      = out_valid_r && out_ready;
        beat_red_s  = reduce_beat(in_data);
        frame_res_s = combine(acc_r, beat_red_s);
    end

    // Next-state logic of the frame FSM.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s && in_last) begin
                    state_nxt_s = HOLD;
                end else if (accept_s) begin
                    state_nxt_s = ACCUM;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACCUM: begin
                if (accept_s && in_last) begin
                    state_nxt_s = HOLD;
                end else begin
                    state_nxt_s = ACCUM;
                end
            end
            HOLD: begin
                // A beat can only be accepted here together with a transfer.
                if (accept_s && in_last) begin
                    state_nxt_s = HOLD;
                end else if (accept_s) begin
                    state_nxt_s = ACCUM;
                end else if (xfer_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Next values of the accumulator and the result registers.
    always_comb begin
        acc_nxt_s       = acc_r;
        out_data_nxt_s  = out_data_r;
        out_any_nxt_s   = out_any_r;
        out_valid_nxt_s = out_valid_r && (!xfer_s);
        if (accept_s && in_last) begin
            out_data_nxt_s  = frame_res_s;
            out_any_nxt_s   = |frame_res_s;
            out_valid_nxt_s = 1'b1;
            acc_nxt_s       = IDENT;
        end else if (accept_s) begin
            acc_nxt_s       = frame_res_s;
        end else begin
            acc_nxt_s       = acc_r;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            acc_r       <= IDENT;
            out_data_r  <= {WIDTH{1'b0}};
            out_any_r   <= 1'b0;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            acc_r       <= acc_nxt_s;
            out_data_r  <= out_data_nxt_s;
            out_any_r   <= out_any_nxt_s;
            out_valid_r <= out_valid_nxt_s;
        end
    end

`ifdef MULTI_INPUT_OR_ACCUM_BEATCNT_EN
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] r;
        if (c == {CNT_W{1'b1}}) begin
            r = c;
        end else begin
            r = c + CNT_W'(1);
        end
        return r;
    endfunction

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] out_beats_r;
    logic [CNT_W-1:0] out_beats_nxt_s;

    // Beats seen so far in the open frame; the count is published with the result.
    always_comb begin
        cnt_nxt_s       = cnt_r;
        out_beats_nxt_s = out_beats_r;
        if (accept_s && in_last) begin
            out_beats_nxt_s = sat_inc(cnt_r);
            cnt_nxt_s       = {CNT_W{1'b0}};
        end else if (accept_s) begin
            cnt_nxt_s       = sat_inc(cnt_r);
        end else begin
            cnt_nxt_s       = cnt_r;
        end
    end

    // Beat counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= {CNT_W{1'b0}};
            out_beats_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r       <= cnt_nxt_s;
            out_beats_r <= out_beats_nxt_s;
        end
    end

    assign out_beats = out_beats_r;
`endif

    assign in_ready  = in_ready_s;
    assign out_data  = out_data_r;
    assign out_any   = out_any_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_multi_input_or_accum.sv
// Self-checking bench: an OR instance and an AND instance share one stimulus stream and are
// compared against a frame-level reference model kept as a queue of accepted beats.
module tb_multi_input_or_accum;

    localparam int NI = 3;
    localparam int W  = 4;

    logic            clk;
    logic            rst_n;
    logic [NI*W-1:0] in_data;
    logic            in_valid;
    logic            in_last;
    logic            out_ready;

    logic         or_ready, or_any, or_valid;
    logic [W-1:0] or_data;
    logic         and_ready, and_any, and_valid;
    logic [W-1:0] and_data;
`ifdef MULTI_INPUT_OR_ACCUM_BEATCNT_EN
    logic [7:0]   or_beats;
    logic [1:0]   and_beats;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [NI*W-1:0] frame_q[$];
    logic            exp_valid;
    logic [W-1:0]    exp_or;
    logic [W-1:0]    exp_and;
    int              exp_cnt;

    multi_input_or_accum #(.NUM_INPUTS(NI), .WIDTH(W), .MODE(0), .CNT_W(8)) u_or (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(or_ready), .out_data(or_data), .out_any(or_any), .out_valid(or_valid),
`ifdef MULTI_INPUT_OR_ACCUM_BEATCNT_EN
        .out_beats(or_beats),
`endif
        .out_ready(out_ready)
    );

    multi_input_or_accum #(.NUM_INPUTS(NI), .WIDTH(W), .MODE(1), .CNT_W(2)) u_and (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(and_ready), .out_data(and_data), .out_any(and_any), .out_valid(and_valid),
`ifdef MULTI_INPUT_OR_ACCUM_BEATCNT_EN
        .out_beats(and_beats),
`endif
        .out_ready(out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Whole-frame result computed from every word of every accepted beat.
    function automatic logic [W-1:0] ref_frame(input bit is_and);
        logic [W-1:0] r;
        logic [W-1:0] w;
        r = is_and ? 4'hF : 4'h0;
        foreach (frame_q[i]) begin
            for (int k = 0; k < NI; k++) begin
                w = frame_q[i][k*W +: W];
                r = is_and ? (r & w) : (r | w);
            end
        end
        return r;
    endfunction

    task automatic check_outputs();
        check("or_valid", or_valid, exp_valid);
        check("and_valid", and_valid, exp_valid);
        if (exp_valid) begin
            check("or_data", or_data, exp_or);
            check("or_any", or_any, |exp_or);
            check("and_data", and_data, exp_and);
            check("and_any", and_any, |exp_and);
`ifdef MULTI_INPUT_OR_ACCUM_BEATCNT_EN
            check("or_beats", or_beats, (exp_cnt > 255) ? 255 : exp_cnt);
            check("and_beats", and_beats, (exp_cnt > 3) ? 3 : exp_cnt);
`endif
        end
    endtask

    // One clock cycle: drive inputs after the edge, check in_ready, advance, check outputs.
    task automatic cycle(input logic v, input logic l, input logic [NI*W-1:0] d, input logic ordy);
        logic exp_rdy, acc, xfer;
        in_valid  = v;
        in_last   = l;
        in_data   = d;
        out_ready = ordy;
        #1;
        exp_rdy = (!exp_valid) || ordy;
        check("or_in_ready", or_ready, exp_rdy);
        check("and_in_ready", and_ready, exp_rdy);
        acc  = v && exp_rdy;
        xfer = exp_valid && ordy;
        @(posedge clk);
        #1;
        if (acc) frame_q.push_back(d);
        if (acc && l) begin
            exp_or    = ref_frame(1'b0);
            exp_and   = ref_frame(1'b1);
            exp_cnt   = frame_q.size();
            frame_q.delete();
            exp_valid = 1'b1;
        end else if (xfer) begin
            exp_valid = 1'b0;
        end
        check_outputs();
    endtask

    task automatic apply_reset();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rst_or_valid", or_valid, 1'b0);
        check("rst_and_valid", and_valid, 1'b0);
        check("rst_or_data", or_data, 4'h0);
        check("rst_and_data", and_data, 4'h0);
        check("rst_or_any", or_any, 1'b0);
        check("rst_or_in_ready", or_ready, 1'b1);
        check("rst_and_in_ready", and_ready, 1'b1);
        frame_q.delete();
        exp_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [NI*W-1:0] d;
        in_data   = '0;
        exp_valid = 1'b0;
        exp_or    = 4'h0;
        exp_and   = 4'h0;
        exp_cnt   = 0;
        apply_reset();

        // Single-beat frame.
        cycle(1'b1, 1'b1, {4'h8, 4'h2, 4'h1}, 1'b1);
        check("req034_data", or_data, 4'hB);
        check("req034_any", or_any, 1'b1);
        cycle(1'b0, 1'b0, 12'h000, 1'b1);

        // Three-beat frame.
        cycle(1'b1, 1'b0, 12'h001, 1'b1);
        cycle(1'b1, 1'b0, 12'h040, 1'b1);
        cycle(1'b1, 1'b1, 12'h000, 1'b1);
        check("req035_data", or_data, 4'h5);
        cycle(1'b0, 1'b0, 12'h000, 1'b1);

        // AND-mode frame, then an all-zero frame.
        cycle(1'b1, 1'b0, 12'hFEF, 1'b1);
        cycle(1'b1, 1'b1, 12'h7FF, 1'b1);
        check("req036_and_data", and_data, 4'h6);
        cycle(1'b1, 1'b1, 12'h000, 1'b1);
        check("req036_and_any", and_any, 1'b0);
        check("req036_or_any", or_any, 1'b0);
        cycle(1'b0, 1'b0, 12'h000, 1'b1);

        // Backpressure: result must hold while offered beats are refused.
        cycle(1'b1, 1'b1, 12'h123, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, 1'b1, 12'h0FF, 1'b0);
            check("req037_hold", or_data, 4'h3);
            check("req037_in_ready", or_ready, 1'b0);
        end
        cycle(1'b1, 1'b1, 12'h002, 1'b1);
        check("req037_new", or_data, 4'h2);
        check("req037_valid", or_valid, 1'b1);
        cycle(1'b0, 1'b0, 12'h000, 1'b1);

        // Reset mid-frame discards the partial frame.
        cycle(1'b1, 1'b0, 12'hF00, 1'b1);
        cycle(1'b1, 1'b0, 12'h0E0, 1'b1);
        apply_reset();
        cycle(1'b1, 1'b1, 12'h001, 1'b1);
        check("req038_data", or_data, 4'h1);
        cycle(1'b0, 1'b0, 12'h000, 1'b1);

        // Five-beat frame saturates the 2-bit counter of the AND instance.
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, (i == 4), 12'h111, 1'b1);
        end
`ifdef MULTI_INPUT_OR_ACCUM_BEATCNT_EN
        check("req039_sat", and_beats, 2'd3);
        check("req039_or_cnt", or_beats, 8'd5);
`endif
        cycle(1'b0, 1'b0, 12'h000, 1'b1);

        // Randomized traffic with mixed sparse and dense data.
        for (int i = 0; i < 400; i++) begin
            if (i % 2 == 0) begin
                d = NI*W'($urandom & $urandom & $urandom);
            end else begin
                d = NI*W'($urandom | $urandom);
            end
            cycle(($urandom_range(0, 3) != 0), ($urandom_range(0, 3) == 0), d,
                  ($urandom_range(0, 3) != 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
